// File: rtl/pwm_pkg.sv
// Shared constants and FSM state type for the PWM capture block.
package pwm_pkg;

   localparam int unsigned DUTY_W = 7;
   localparam logic [DUTY_W-1:0] PCT_SCALE = 7'd100;
   localparam int unsigned DIV_ITER = 7;

   typedef enum logic [1:0] {IDLE, MEAS, DIV} state_e;

endpackage

// File: rtl/pwm_duty_div.sv
// Restoring divider: q = floor(h * 100 / p), 1 load cycle + 7 iterate cycles.
module pwm_duty_div
   import pwm_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [CNT_W-1:0]  h,
   input  logic [CNT_W-1:0]  p,
   output logic              busy,
   output logic              done,
   output logic [DUTY_W-1:0] q
);

   localparam int unsigned DW = CNT_W + DUTY_W;
   localparam logic [2:0] LAST = 3'(DIV_ITER);

   logic [DW-1:0]     dividend;
   logic [CNT_W-1:0]  rem_q;
   logic [CNT_W-1:0]  dvs_q;
   logic [DUTY_W-1:0] quo_q;
   logic [2:0]        iter_q;
   logic              busy_q;
   logic [CNT_W:0]    trial;
   logic              ge;
   logic [CNT_W-1:0]  diff;

   always_comb begin
      dividend = DW'(h) * DW'(PCT_SCALE);
      trial    = {rem_q, quo_q[DUTY_W-1]};
      ge       = trial >= {1'b0, dvs_q};
      // rem < p always holds, so the true difference fits in CNT_W bits
      diff     = trial[CNT_W-1:0] - dvs_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rem_q  <= '0;
         dvs_q  <= '0;
         quo_q  <= '0;
         iter_q <= '0;
         busy_q <= 1'b0;
      end else if (start) begin
         // h <= p bounds the quotient below 128, so the top bits start below p
         rem_q  <= dividend[DW-1:DUTY_W];
         quo_q  <= dividend[DUTY_W-1:0];
         dvs_q  <= p;
         iter_q <= '0;
         busy_q <= 1'b1;
      end else if (busy_q) begin
         if (iter_q == LAST) begin
            busy_q <= 1'b0;
         end else begin
            rem_q  <= ge ? diff : trial[CNT_W-1:0];
            quo_q  <= {quo_q[DUTY_W-2:0], ge};
            iter_q <= iter_q + 3'd1;
         end
      end
   end

   assign busy = busy_q;
   assign done = busy_q && (iter_q == LAST);
   assign q    = quo_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures period, high time and duty cycle of an asynchronous PWM input,
// with stuck-input detection via a rising-edge timeout.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pwm_in,
   output logic [DUTY_W-1:0] duty_pct,
   output logic              duty_valid,
   output logic [CNT_W-1:0]  period_out,
   output logic [CNT_W-1:0]  high_out,
   output logic              stuck,
   output logic              overrun,
   output logic              busy
);

   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [1:0]        rst_sync_q;
   logic              rst_n;
   logic              pwm_meta_q, pwm_sync_q, pwm_hist_q;
   logic              rise;
   logic [CNT_W-1:0]  per_q, per_d, per_inc;
   logic [CNT_W-1:0]  hi_q, hi_d, hi_inc;
   logic              timeout_hit;
   state_e            state_q;
   logic              stuck_seen_q;
   logic              discard_q;
   logic [CNT_W-1:0]  p_lat_q, h_lat_q;
   logic              div_start, div_done, div_busy;
   logic [DUTY_W-1:0] div_quot;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rst_sync_q <= '0;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   assign rise = pwm_sync_q & ~pwm_hist_q;

   always_comb begin
      per_inc     = (per_q == TMO) ? per_q : per_q + ONE;
      hi_inc      = (pwm_sync_q && hi_q != TMO) ? hi_q + ONE : hi_q;
      // One report per stuck episode; a rise always takes priority
      timeout_hit = (per_inc == TMO) && !rise && (state_q != DIV) && !stuck_seen_q;
      per_d       = per_inc;
      hi_d        = hi_inc;
      if (rise) begin
         per_d = ONE;
         hi_d  = ONE;
      end else if (timeout_hit) begin
         per_d = '0;
         hi_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_meta_q <= 1'b0;
         pwm_sync_q <= 1'b0;
         pwm_hist_q <= 1'b0;
         per_q      <= '0;
         hi_q       <= '0;
      end else begin
         pwm_meta_q <= pwm_in;
         pwm_sync_q <= pwm_meta_q;
         pwm_hist_q <= pwm_sync_q;
         per_q      <= per_d;
         hi_q       <= hi_d;
      end
   end

   assign div_start = (state_q == MEAS) && rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         stuck_seen_q <= 1'b0;
         discard_q    <= 1'b0;
         p_lat_q      <= '0;
         h_lat_q      <= '0;
         duty_pct     <= '0;
         duty_valid   <= 1'b0;
         period_out   <= '0;
         high_out     <= '0;
         stuck        <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         duty_valid <= 1'b0;
         if (rise) stuck_seen_q <= 1'b0;
         if (timeout_hit) begin
            duty_valid   <= 1'b1;
            duty_pct     <= pwm_sync_q ? PCT_SCALE : '0;
            period_out   <= '0;
            high_out     <= '0;
            stuck        <= 1'b1;
            stuck_seen_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (rise) state_q <= MEAS;
            end
            MEAS: begin
               if (rise) begin
                  p_lat_q <= per_q;
                  h_lat_q <= hi_q;
                  state_q <= DIV;
               end else if (timeout_hit) begin
                  state_q <= IDLE;
               end
            end
            DIV: begin
               // A period shorter than the divide discards the result in flight
               if (rise) begin
                  overrun   <= 1'b1;
                  discard_q <= 1'b1;
               end
               if (div_done) begin
                  state_q   <= MEAS;
                  discard_q <= 1'b0;
                  if (!discard_q && !rise) begin
                     duty_valid <= 1'b1;
                     duty_pct   <= div_quot;
                     period_out <= p_lat_q;
                     high_out   <= h_lat_q;
                     stuck      <= 1'b0;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   pwm_duty_div #(
      .CNT_W (CNT_W)
   ) u_div (
      .clk   (clk),
      .reset (rst_n),
      .start (div_start),
      .h     (hi_q),
      .p     (per_q),
      .busy  (div_busy),
      .done  (div_done),
      .q     (div_quot)
   );

   assign busy = div_busy;

endmodule
